// File: rtl/fir_tdm_sequencer.sv
// Time-multiplexed FIR: one MAC walks TAPS coefficient slots per sample
// against a circular history, then holds the result until taken.
module fir_tdm_sequencer #(
  parameter int TAPS   = 16,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [ACC_W-1:0]         m_data,
  output logic                     busy
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [AW:0]   TAPS_W = (AW+1)'(TAPS);
  localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] p_q, p_d;
  logic [AW-1:0] idx_q, idx_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0]        mdata_q, mdata_d;
  logic                    mvalid_q, mvalid_d;

  logic signed [DATA_W-1:0] hist_q [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];

  logic          accept;
  logic          coef_wr;
  logic [AW:0]   rd_sum;
  logic [AW-1:0] rd_idx;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] mac_sum;

  assign s_ready = ena & (state_q == S_IDLE);
  assign busy    = (state_q == S_MAC) | (state_q == S_HOLD);
  assign m_valid = mvalid_q;
  assign m_data  = mdata_q;

  assign accept  = s_valid & s_ready;

  // MAC state excluded so one result never mixes two coefficient sets
  assign coef_wr = ena & coef_we
                 & (state_q != S_MAC)
                 & ({1'b0, coef_addr} < TAPS_W);

  // (p - idx) mod TAPS without relying on power-of-two wrap
  always_comb begin
    if (p_q >= idx_q) begin
      rd_sum = {1'b0, p_q} - {1'b0, idx_q};
    end else begin
      rd_sum = {1'b0, p_q} + TAPS_W - {1'b0, idx_q};
    end
    rd_idx = rd_sum[AW-1:0];
  end

  assign prod     = hist_q[rd_idx] * coef_q[idx_q];
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign mac_sum  = acc_q + prod_ext;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    p_d      = p_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    if (ena) begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (accept) begin
            p_d     = wptr_q;
            wptr_d  = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_MAC;
          end
        end
        (state_q == S_MAC): begin
          acc_d = mac_sum;
          if (idx_q == LAST) begin
            mdata_d  = mac_sum;
            mvalid_d = 1'b1;
            state_d  = S_HOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        (state_q == S_HOLD): begin
          if (m_ready) begin
            mvalid_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      p_q      <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      p_q      <= p_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        hist_q[wptr_q] <= s_data;
      end
      if (coef_wr) begin
        coef_q[coef_addr] <= coef_wdata;
      end
    end
  end

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Directed bench for fir_tdm_sequencer: impulse, step, extremes,
// backpressure, coefficient lock, mid-MAC reset and enable stall.
module tb_fir_tdm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        m_valid;
  logic        m_ready;
  logic [35:0] m_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fir_tdm_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic longint mres();
    return longint'($signed(m_data));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    ena     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    coef_we = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    m_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wcoef(input int k, input int v);
    coef_we    = 1'b1;
    coef_addr  = 4'(k);
    coef_wdata = 16'(v);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < 16; k++) wcoef(k, v);
  endtask

  task automatic accept(input int s);
    int n = 0;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    chk("rdy_wait", longint'(s_ready), 1);
    s_valid = 1'b1;
    s_data  = 16'(s);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_out(input int n0, output int lat);
    int n = n0;
    lat = -1;
    while (n < 200) begin
      tick();
      n++;
      if (m_valid) begin
        lat = n;
        break;
      end
    end
    chk("val_wait", longint'(m_valid), 1);
  endtask

  task automatic send(input int s, output longint r, output int lat);
    accept(s);
    wait_out(0, lat);
    r = mres();
  endtask

  longint r;
  longint r_ref;
  int     lat;

  initial begin
    rst = 1'b0;
    do_reset();
    chk("rst_mvalid", longint'(m_valid), 0);
    chk("rst_mdata",  mres(), 0);
    chk("rst_busy",   longint'(busy), 0);
    chk("rst_sready", longint'(s_ready), 1);

    // impulse: coef[k]=k+1
    for (int k = 0; k < 16; k++) wcoef(k, k + 1);
    for (int j = 0; j < 20; j++) begin
      send((j == 0) ? 1 : 0, r, lat);
      chk($sformatf("imp%0d", j), r, (j < 16) ? j + 1 : 0);
    end

    // step of 100 with unit coefficients
    fill(1);
    for (int j = 0; j < 20; j++) begin
      send(100, r, lat);
      chk($sformatf("step%0d", j), r, (j < 16) ? 100 * (j + 1) : 1600);
      chk($sformatf("lat%0d", j), lat, 16);
    end

    // extremes against a history of 100s
    fill(32767);
    for (int j = 0; j < 16; j++) begin
      send(-32768, r, lat);
      if (j == 0) chk("ext_first", r, -64'sd1024558556);
    end
    chk("ext_last", r, -64'sd17179344896);
    chk("ext_bits", longint'(m_data), 64'h0000_000C_0008_0000);

    // backpressure and coefficient lock
    do_reset();
    fill(1);
    wcoef(0, 3);
    m_ready = 1'b0;
    accept(10);
    coef_we    = 1'b1;
    coef_addr  = 4'd0;
    coef_wdata = 16'd7;
    tick();
    coef_we = 1'b0;
    wait_out(1, lat);
    chk("bp_data", mres(), 30);
    chk("bp_lat", lat, 16);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_v",   longint'(m_valid), 1);
      chk("hold_d",   mres(), 30);
      chk("hold_rdy", longint'(s_ready), 0);
      chk("hold_busy", longint'(busy), 1);
    end
    m_ready = 1'b1;
    tick();
    chk("rel_v", longint'(m_valid), 0);
    send(5, r, lat);
    chk("lock_next", r, 25);

    // reset mid-MAC
    do_reset();
    fill(1);
    send(1000, r, lat);
    chk("pre_rst", r, 1000);
    accept(1000);
    repeat (7) tick();
    rst = 1'b0;
    #1;
    chk("mr_mvalid", longint'(m_valid), 0);
    chk("mr_busy",   longint'(busy), 0);
    chk("mr_mdata",  mres(), 0);
    tick();
    rst = 1'b1;
    tick();
    fill(1);
    send(5, r, lat);
    chk("mr_imp", r, 5);

    // enable stall: reference run first
    do_reset();
    for (int k = 0; k < 16; k++) wcoef(k, k + 1);
    send(3, r, lat);
    send(4, r_ref, lat);
    chk("ref_data", r_ref, 10);
    chk("ref_lat", lat, 16);

    do_reset();
    for (int k = 0; k < 16; k++) wcoef(k, k + 1);
    send(3, r, lat);
    accept(4);
    repeat (4) tick();
    ena = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("st_rdy", longint'(s_ready), 0);
      chk("st_v",   longint'(m_valid), 0);
    end
    ena = 1'b1;
    wait_out(7, lat);
    chk("st_data", mres(), r_ref);
    chk("st_lat", lat, 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
